// File: rtl/multislope_seq.sv
// rtl/multislope_seq.sv - multi-slope ADC conversion sequencer driving pwmgen
module multislope_seq #(
    parameter int PERIOD        = 259,
    parameter int RUNUP_PERIODS = 1000,
    parameter int ZERO_CYC      = 64,
    parameter int RUNDOWN_MAX   = 4095,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_req,
    input  logic             abort,
    input  logic             comp,
    input  logic             result_ack,
    output logic             pwm_start,
    output logic             pwm_enable,
    output logic             pwm_mode,
    output logic             integ_reset,
    output logic             rundown_pos,
    output logic             rundown_neg,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] rundown_count,
    output logic             rundown_sign,
    output logic             timeout
);

    localparam int PH_W = $clog2(PERIOD + 1);
    localparam int PC_W = (RUNUP_PERIODS > 1) ? $clog2(RUNUP_PERIODS) : 1;
    localparam int ZC_W = (ZERO_CYC > 1) ? $clog2(ZERO_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_RUNUP,
        S_RUNDOWN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              comp_s1;
    logic              comp_s;
    logic [ZC_W-1:0]   zc;
    logic [PH_W-1:0]   ph;
    logic [PC_W-1:0]   pc;
    logic              zc_last;
    logic              ph_last;
    logic              pc_last;
    logic              crossing;
    logic              at_max;

    assign zc_last  = (zc == ZC_W'(ZERO_CYC - 1));
    assign ph_last  = (ph == PH_W'(PERIOD));
    assign pc_last  = (pc == PC_W'(RUNUP_PERIODS - 1));
    assign crossing = (comp_s != rundown_sign);
    assign at_max   = (rundown_count == CNT_W'(RUNDOWN_MAX));

    // two-flop synchronizer for the asynchronous comparator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_s1 <= 1'b0;
            comp_s  <= 1'b0;
        end else begin
            comp_s1 <= comp;
            comp_s  <= comp_s1;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and control outputs, decoded from the current state
    always_comb begin
        state_next   = state;
        integ_reset  = 1'b0;
        pwm_start    = 1'b0;
        pwm_enable   = 1'b0;
        rundown_pos  = 1'b0;
        rundown_neg  = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        case (state)
            S_IDLE: begin
                integ_reset = 1'b1;
                busy        = 1'b0;
                if (conv_req) begin
                    state_next = S_ZERO;
                end
            end
            S_ZERO: begin
                integ_reset = 1'b1;
                pwm_start   = 1'b1;
                if (zc_last) begin
                    state_next = S_RUNUP;
                end
            end
            S_RUNUP: begin
                pwm_enable = 1'b1;
                if (ph_last && pc_last) begin
                    state_next = S_RUNDOWN;
                end
            end
            S_RUNDOWN: begin
                rundown_neg = rundown_sign;
                rundown_pos = !rundown_sign;
                if (crossing || at_max) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // discharge counter and run-up phase/period counters, ph tracks pwmgen count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zc <= '0;
            ph <= '0;
            pc <= '0;
        end else if (state == S_ZERO) begin
            zc <= zc + 1'b1;
            ph <= '0;
            pc <= '0;
        end else if (state == S_RUNUP) begin
            zc <= '0;
            ph <= ph_last ? '0 : ph + 1'b1;
            if (ph_last) begin
                pc <= pc + 1'b1;
            end
        end else begin
            zc <= '0;
        end
    end

    // charge-balance mode: sampled one cycle before pwmgen wraps so it is stable at count==0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_mode <= 1'b0;
        end else if (state == S_ZERO) begin
            pwm_mode <= 1'b0;
        end else if (state == S_RUNUP && ph == PH_W'(PERIOD - 1)) begin
            pwm_mode <= comp_s;
        end
    end

    // run-down residue: cleared in ZERO, sign latched entering RUNDOWN, frozen outside RUNDOWN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rundown_count <= '0;
            rundown_sign  <= 1'b0;
            timeout       <= 1'b0;
        end else if (state == S_ZERO) begin
            rundown_count <= '0;
            rundown_sign  <= 1'b0;
            timeout       <= 1'b0;
        end else if (state == S_RUNUP && state_next == S_RUNDOWN) begin
            rundown_sign <= comp_s;
        end else if (state == S_RUNDOWN) begin
            if (state_next == S_RUNDOWN) begin
                rundown_count <= rundown_count + 1'b1;
            end else if (state_next == S_DONE && !crossing) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multislope_seq.sv
// tb/tb_multislope_seq.sv - directed self-checking bench for multislope_seq
module tb_multislope_seq;

    localparam int PERIOD        = 259;
    localparam int RUNUP_PERIODS = 3;
    localparam int ZERO_CYC      = 4;
    localparam int RUNDOWN_MAX   = 4095;
    localparam int CNT_W         = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             conv_req = 1'b0;
    logic             abort = 1'b0;
    logic             comp = 1'b0;
    logic             result_ack = 1'b0;
    logic             pwm_start;
    logic             pwm_enable;
    logic             pwm_mode;
    logic             integ_reset;
    logic             rundown_pos;
    logic             rundown_neg;
    logic             busy;
    logic             result_valid;
    logic [CNT_W-1:0] rundown_count;
    logic             rundown_sign;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    multislope_seq #(
        .PERIOD(PERIOD), .RUNUP_PERIODS(RUNUP_PERIODS), .ZERO_CYC(ZERO_CYC),
        .RUNDOWN_MAX(RUNDOWN_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .conv_req(conv_req), .abort(abort), .comp(comp),
        .result_ack(result_ack), .pwm_start(pwm_start), .pwm_enable(pwm_enable),
        .pwm_mode(pwm_mode), .integ_reset(integ_reset), .rundown_pos(rundown_pos),
        .rundown_neg(rundown_neg), .busy(busy), .result_valid(result_valid),
        .rundown_count(rundown_count), .rundown_sign(rundown_sign), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // one-cycle conv_req pulse; returns just after the edge that enters ZERO
    task automatic start_conv();
        @(posedge clk); #1 conv_req = 1'b1;
        @(posedge clk); #1 conv_req = 1'b0;
    endtask

    task automatic settle_comp(input logic v);
        comp = v;
        repeat (4) @(posedge clk);
    endtask

    task automatic ack_result();
        @(negedge clk); result_ack = 1'b1;
        @(posedge clk); #1 result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (integ_reset !== 1'b1) begin errors++; $display("FAIL reset_integ_reset got %b expected 1", integ_reset); end
        checks++; if ({pwm_start, pwm_enable, pwm_mode, rundown_pos, rundown_neg} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b expected 00000", {pwm_start, pwm_enable, pwm_mode, rundown_pos, rundown_neg}); end
        checks++; if ({busy, result_valid, rundown_sign, timeout} !== 4'b0) begin errors++; $display("FAIL reset_status got %b expected 0000", {busy, result_valid, rundown_sign, timeout}); end
        checks++; if (rundown_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", rundown_count); end
        rst = 1'b0;
    endtask

    // comp=0: ZERO length, run-up length, no mode change, positive run-down entry latency
    task automatic test_runup();
        int n = 0, start_cnt = 0, en_cnt = 0, mode_hi = 0;
        logic got = 1'b0;
        settle_comp(1'b0);
        start_conv();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n++;
            if (pwm_start) start_cnt++;
            if (pwm_enable) en_cnt++;
            if (pwm_mode) mode_hi++;
            if (rundown_pos) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL runup_reach_rundown got %b expected 1", got); end
        checks++; if (n != 785) begin errors++; $display("FAIL runup_latency got %0d expected 785", n); end
        checks++; if (start_cnt != 4) begin errors++; $display("FAIL runup_start_cycles got %0d expected 4", start_cnt); end
        checks++; if (en_cnt != 780) begin errors++; $display("FAIL runup_enable_cycles got %0d expected 780", en_cnt); end
        checks++; if (mode_hi != 0) begin errors++; $display("FAIL runup_mode_high got %0d expected 0", mode_hi); end
        checks++; if ({rundown_neg, pwm_enable, integ_reset, busy} !== 4'b0001) begin errors++; $display("FAIL runup_rd_entry got %b expected 0001", {rundown_neg, pwm_enable, integ_reset, busy}); end
    endtask

    // continues from run-down entry with comp constant: saturate at RUNDOWN_MAX
    task automatic test_timeout();
        int pos_cnt = 1;
        logic got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (result_valid) begin got = 1'b1; break; end
            if (rundown_pos) pos_cnt++;
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_done got %b expected 1", got); end
        checks++; if (pos_cnt != 4096) begin errors++; $display("FAIL to_rundown_cycles got %0d expected 4096", pos_cnt); end
        checks++; if (rundown_count !== 16'd4095) begin errors++; $display("FAIL to_count got %0d expected 4095", rundown_count); end
        checks++; if ({timeout, rundown_sign, rundown_pos, rundown_neg} !== 4'b1000) begin errors++; $display("FAIL to_flags got %b expected 1000", {timeout, rundown_sign, rundown_pos, rundown_neg}); end
        repeat (3) @(negedge clk);
        checks++; if ({result_valid, rundown_count} !== {1'b1, 16'd4095}) begin errors++; $display("FAIL to_hold got %b/%0d expected 1/4095", result_valid, rundown_count); end
        ack_result();
        checks++; if ({result_valid, busy, integ_reset} !== 3'b001) begin errors++; $display("FAIL to_ack got %b expected 001", {result_valid, busy, integ_reset}); end
        checks++; if (rundown_count !== 16'd4095) begin errors++; $display("FAIL to_idle_hold got %0d expected 4095", rundown_count); end
    endtask

    // comp=1 through run-up, falls 100 cycles into run-down
    task automatic test_rundown_neg();
        int n = 0, en_idx = -1, first_mode = -1, mode_changes = 0;
        logic prev_mode = 1'b0;
        logic got = 1'b0;
        settle_comp(1'b1);
        start_conv();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                checks++; if ({rundown_count, timeout} !== 17'd0) begin errors++; $display("FAIL neg_zero_clear got %0d/%b expected 0/0", rundown_count, timeout); end
            end
            if (pwm_enable) begin
                en_idx++;
                if (pwm_mode !== prev_mode) begin
                    mode_changes++;
                    if (first_mode < 0) first_mode = en_idx;
                end
                prev_mode = pwm_mode;
            end
            if (rundown_neg) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL neg_reach_rundown got %b expected 1", got); end
        checks++; if (first_mode != 259) begin errors++; $display("FAIL neg_mode_index got %0d expected 259", first_mode); end
        checks++; if (mode_changes != 1) begin errors++; $display("FAIL neg_mode_changes got %0d expected 1", mode_changes); end
        checks++; if (rundown_pos !== 1'b0) begin errors++; $display("FAIL neg_pos_off got %b expected 0", rundown_pos); end
        repeat (100) @(posedge clk);
        #1 comp = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (result_valid) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL neg_done got %b expected 1", got); end
        checks++; if (rundown_count !== 16'd102) begin errors++; $display("FAIL neg_count got %0d expected 102", rundown_count); end
        checks++; if ({rundown_sign, timeout, rundown_pos, rundown_neg, busy} !== 5'b10001) begin errors++; $display("FAIL neg_flags got %b expected 10001", {rundown_sign, timeout, rundown_pos, rundown_neg, busy}); end
        ack_result();
    endtask

    // abort at run-down cycle 10, then a clean conversion
    task automatic test_abort();
        int rv_hi = 0;
        logic got = 1'b0;
        logic mode_chk = 1'b0;
        settle_comp(1'b1);
        start_conv();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pwm_enable && !mode_chk) begin
                mode_chk = 1'b1;
                checks++; if (pwm_mode !== 1'b0) begin errors++; $display("FAIL ab_mode_init got %b expected 0", pwm_mode); end
            end
            if (rundown_neg) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL ab_reach_rundown got %b expected 1", got); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if ({rundown_neg, rundown_count} !== {1'b1, 16'd10}) begin errors++; $display("FAIL ab_cycle10 got %b/%0d expected 1/10", rundown_neg, rundown_count); end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        checks++; if ({busy, rundown_neg, rundown_pos, result_valid, integ_reset} !== 5'b00001) begin errors++; $display("FAIL ab_idle got %b expected 00001", {busy, rundown_neg, rundown_pos, result_valid, integ_reset}); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid || busy) rv_hi++;
        end
        checks++; if (rv_hi != 0) begin errors++; $display("FAIL ab_no_result got %0d expected 0", rv_hi); end
        start_conv();
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rundown_neg) begin got = 1'b1; break; end
        end
        repeat (20) @(posedge clk);
        #1 comp = 1'b0;
        for (int i = 0; i < 200 && got; i++) begin
            @(negedge clk);
            if (result_valid) break;
        end
        checks++; if ({result_valid, rundown_count, timeout} !== {1'b1, 16'd22, 1'b0}) begin errors++; $display("FAIL ab_next_conv got %b/%0d/%b expected 1/22/0", result_valid, rundown_count, timeout); end
        ack_result();
    endtask

    // conv_req held high across DONE and ack: one IDLE cycle, then a single ZERO
    task automatic test_back_to_back();
        int bad = 0, start_cnt = 0;
        logic got = 1'b0;
        settle_comp(1'b1);
        @(posedge clk); #1 conv_req = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rundown_neg) begin got = 1'b1; break; end
        end
        repeat (5) @(posedge clk);
        #1 comp = 1'b0;
        for (int i = 0; i < 200 && got; i++) begin
            @(negedge clk);
            if (result_valid) break;
        end
        checks++; if ({result_valid, rundown_count} !== {1'b1, 16'd7}) begin errors++; $display("FAIL b2b_done got %b/%0d expected 1/7", result_valid, rundown_count); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pwm_start || !result_valid) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_done_hold got %0d expected 0", bad); end
        ack_result();
        checks++; if ({busy, pwm_start, result_valid} !== 3'b000) begin errors++; $display("FAIL b2b_idle got %b expected 000", {busy, pwm_start, result_valid}); end
        @(posedge clk); #1;
        checks++; if ({busy, pwm_start} !== 2'b11) begin errors++; $display("FAIL b2b_restart got %b expected 11", {busy, pwm_start}); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pwm_start) start_cnt++;
        end
        checks++; if (start_cnt != 4) begin errors++; $display("FAIL b2b_single_zero got %0d expected 4", start_cnt); end
        conv_req = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_abort got %b expected 0", busy); end
    endtask

    // asynchronous reset pulse in the middle of run-up
    task automatic test_reset_midrun();
        settle_comp(1'b0);
        start_conv();
        repeat (300) @(negedge clk);
        checks++; if ({pwm_enable, busy} !== 2'b11) begin errors++; $display("FAIL rst_mid_pre got %b expected 11", {pwm_enable, busy}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({integ_reset, pwm_enable, result_valid, busy, pwm_start} !== 5'b10000) begin errors++; $display("FAIL rst_mid_async got %b expected 10000", {integ_reset, pwm_enable, result_valid, busy, pwm_start}); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, pwm_enable, integ_reset} !== 3'b001) begin errors++; $display("FAIL rst_mid_after got %b expected 001", {busy, pwm_enable, integ_reset}); end
    endtask

    initial begin
        test_reset();
        test_runup();
        test_timeout();
        test_rundown_neg();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
